// File: rtl/alu_result_bcd.sv
`default_nettype none
// ============================================================================
// alu_result_bcd : iterative double-dabble, ALU result -> sign + packed BCD
// Rev 1.0
// ============================================================================
module alu_result_bcd #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5,
   parameter int SIGNED = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      value,
   output logic                  busy,
   output logic                  done,
   output logic                  neg,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int C_CNT_W = $clog2(WIDTH + 1);
   localparam int C_BCD_W = 4 * DIGITS;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]           r_state;
   logic [WIDTH-1:0]     r_mag;
   logic [C_BCD_W-1:0]   r_scratch;
   logic [C_CNT_W-1:0]   r_count;
   logic                 r_neg_pend;
   logic [C_BCD_W-1:0]   r_bcd;
   logic                 r_neg;

   logic                 w_neg_in;
   logic [WIDTH-1:0]     w_mag_in;
   logic [C_BCD_W-1:0]   w_adj;
   logic [C_BCD_W-1:0]   w_shifted;

   // Negation is done as an unsigned WIDTH-bit value so the most negative input maps to 2^(WIDTH-1).
   assign w_neg_in = (SIGNED != 0) && value[WIDTH-1];
   assign w_mag_in = w_neg_in ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

   genvar d;
   generate
      for (d = 0; d < DIGITS; d++) begin : g_digit
         assign w_adj[4*d +: 4] = (r_scratch[4*d +: 4] >= 4'd5) ?
                                  (r_scratch[4*d +: 4] + 4'd3) : r_scratch[4*d +: 4];
      end
   endgenerate

   assign w_shifted = {w_adj[C_BCD_W-2:0], r_mag[WIDTH-1]};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_mag      <= '0;
         r_scratch  <= '0;
         r_count    <= '0;
         r_neg_pend <= 1'b0;
         r_bcd      <= '0;
         r_neg      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mag      <= w_mag_in;
                  r_neg_pend <= w_neg_in;
                  r_scratch  <= '0;
                  r_count    <= '0;
                  r_state    <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_scratch <= w_shifted;
               r_mag     <= {r_mag[WIDTH-2:0], 1'b0};
               r_count   <= r_count + 1'b1;
               if (r_count == C_CNT_W'(WIDTH - 1)) begin
                  r_bcd   <= w_shifted;
                  r_neg   <= r_neg_pend;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = (r_state == S_SHIFT);
   assign done = (r_state == S_DONE);
   assign neg  = r_neg;
   assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_bcd.sv
`default_nettype none
// ============================================================================
// tb_alu_result_bcd : bench for alu_result_bcd, signed and unsigned instances
// Rev 1.0
// ============================================================================
module tb_alu_result_bcd;

   localparam int WIDTH  = 16;
   localparam int DIGITS = 5;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [WIDTH-1:0]  value = '0;
   logic              busy_s, done_s, neg_s;
   logic              busy_u, done_u, neg_u;
   logic [4*DIGITS-1:0] bcd_s, bcd_u;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   alu_result_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SIGNED(1)) dut_s (
      .clk(clk), .reset(reset), .start(start), .value(value),
      .busy(busy_s), .done(done_s), .neg(neg_s), .bcd(bcd_s));

   alu_result_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SIGNED(0)) dut_u (
      .clk(clk), .reset(reset), .start(start), .value(value),
      .busy(busy_u), .done(done_u), .neg(neg_u), .bcd(bcd_u));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Decimal digits by plain division, packed one per nibble.
   function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned m);
      logic [4*DIGITS-1:0] r;
      int unsigned x;
      r = '0;
      x = m;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Model: phase 0 idle, 1..WIDTH converting, WIDTH+1 done cycle.
   int                  phase = 0;
   logic [4*DIGITS-1:0] exp_bcd_s, exp_bcd_u, pend_bcd_s, pend_bcd_u;
   logic                exp_neg_s, pend_neg_s;

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         phase = 0;
         exp_bcd_s = '0; exp_bcd_u = '0; exp_neg_s = 1'b0;
      end else if (phase == 0) begin
         if (start) begin
            phase = 1;
            pend_neg_s = value[WIDTH-1];
            pend_bcd_s = to_bcd(value[WIDTH-1] ? (65536 - int'(value)) : int'(value));
            pend_bcd_u = to_bcd(int'(value));
         end
      end else if (phase == WIDTH) begin
         phase = WIDTH + 1;
         exp_bcd_s = pend_bcd_s; exp_bcd_u = pend_bcd_u; exp_neg_s = pend_neg_s;
      end else if (phase == WIDTH + 1) begin
         phase = 0;
      end else begin
         phase++;
      end
   end

   always @(negedge clk) begin
      check("busy_s", 32'(busy_s), 32'(phase >= 1 && phase <= WIDTH));
      check("done_s", 32'(done_s), 32'(phase == WIDTH + 1));
      check("bcd_s",  32'(bcd_s),  32'(exp_bcd_s));
      check("neg_s",  32'(neg_s),  32'(exp_neg_s));
      check("busy_u", 32'(busy_u), 32'(phase >= 1 && phase <= WIDTH));
      check("done_u", 32'(done_u), 32'(phase == WIDTH + 1));
      check("bcd_u",  32'(bcd_u),  32'(exp_bcd_u));
      check("neg_u",  32'(neg_u),  32'd0);
   end

   // Returns at the negedge inside the done cycle; counts busy cycles seen before it.
   task automatic wait_done(output int busy_cnt, output bit ok);
      busy_cnt = 0;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done_s) begin
            ok = 1'b1;
            break;
         end
         if (busy_s) busy_cnt++;
      end
      if (!ok) begin
         n_assert++;
         n_fail++;
         $display("FAIL timeout waiting for done (t=%0t)", $time);
      end
   endtask

   task automatic convert(input logic [WIDTH-1:0] v, output int busy_cnt, output bit ok);
      @(posedge clk); #1;
      start = 1'b1;
      value = v;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(busy_cnt, ok);
   endtask

   initial begin
      int  bc;
      bit  ok;
      int  t1;
      int  dones;
      logic [WIDTH-1:0] v;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_busy", 32'(busy_s), 32'd0);
      check("reset_done", 32'(done_s), 32'd0);
      check("reset_bcd",  32'(bcd_s),  32'd0);
      check("reset_neg",  32'(neg_s),  32'd0);

      convert(16'h3039, bc, ok);
      check("busy_cycles", 32'(bc), 32'd16);
      check("lit_12345", 32'(bcd_s), 32'h12345);
      check("lit_12345_neg", 32'(neg_s), 32'd0);

      convert(16'hFFFF, bc, ok);
      check("lit_ffff_s", 32'(bcd_s), 32'h00001);
      check("lit_ffff_s_neg", 32'(neg_s), 32'd1);
      check("lit_ffff_u", 32'(bcd_u), 32'h65535);
      check("lit_ffff_u_neg", 32'(neg_u), 32'd0);

      convert(16'h8000, bc, ok);
      check("lit_8000_s", 32'(bcd_s), 32'h32768);
      check("lit_8000_s_neg", 32'(neg_s), 32'd1);
      check("lit_8000_u", 32'(bcd_u), 32'h32768);

      convert(16'h0000, bc, ok);
      check("lit_zero", 32'(bcd_s), 32'h00000);
      check("lit_zero_neg", 32'(neg_s), 32'd0);

      // Start during SHIFT must be ignored.
      @(posedge clk); #1;
      start = 1'b1; value = 16'h0064;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 start = 1'b1; value = 16'h0001;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(bc, ok);
      check("lit_ignored_start", 32'(bcd_s), 32'h00100);

      // Held start: consecutive done pulses WIDTH+2 cycles apart.
      @(posedge clk); #1;
      start = 1'b1; value = 16'd5;
      wait_done(bc, ok);
      t1 = cyc;
      wait_done(bc, ok);
      start = 1'b0;
      check("held_spacing", 32'(cyc - t1), 32'd18);
      check("lit_held", 32'(bcd_s), 32'h00005);

      // Reset mid-conversion aborts without a done pulse.
      convert(16'd42, bc, ok);
      check("lit_42", 32'(bcd_s), 32'h00042);
      @(posedge clk); #1;
      start = 1'b1; value = 16'h1234;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(busy_s), 32'd0);
      check("abort_done", 32'(done_s), 32'd0);
      check("abort_bcd",  32'(bcd_s),  32'd0);
      check("abort_neg",  32'(neg_s),  32'd0);
      dones = 0;
      repeat (20) begin
         @(negedge clk);
         if (done_s || done_u) dones++;
      end
      check("abort_no_done", 32'(dones), 32'd0);

      // Value wiggles while converting; only the accepted one counts.
      @(posedge clk); #1;
      start = 1'b1; value = 16'd2345;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done_s) break;
         value = 16'($urandom);
         @(posedge clk); #1;
      end
      check("lit_wiggle", 32'(bcd_s), 32'h02345);

      for (int n = 0; n < 1000; n++) begin
         v = 16'($urandom);
         convert(v, bc, ok);
         for (int d = 0; d < DIGITS; d++)
            check("nibble_legal", 32'(bcd_u[4*d +: 4] <= 4'd9), 32'd1);
      end

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_result_bcd.md
Name: alu_result_bcd

Overview:
- Sequential downstream stage for the ALU's 16-bit `result` bus.
- Accepts one result per `start` pulse and converts it to sign plus packed BCD using iterative double-dabble, one bit per clock.
- Holds the converted digits stable for the seven-segment display driver.
- Uses a start/busy/done handshake so the display logic knows when the digits are fresh.

Parameters:
- WIDTH, 16, input word width; must match the ALU result width.
- DIGITS, 5, number of BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH.
- SIGNED, 1, 1 = `value` is two's complement, 0 = `value` is unsigned.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request conversion of `value`; sampled only in IDLE.
- value  input  WIDTH  ALU result to convert.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when `bcd`/`neg` have just been updated.
- neg  output  1  sign of the last converted value (1 = negative).
- bcd  output  4*DIGITS  packed BCD magnitude; digit 0 = bits [3:0] (ones).

Behaviour:
- Reset (synchronous, `reset`=1 at a rising edge):
  - state=IDLE; `busy`=0, `done`=0, `neg`=0, `bcd`=0.
  - Internal shift, count and scratch registers cleared.
  - Reset overrides `start` in the same cycle.
  - Reset mid-conversion aborts it; no `done` is produced.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - On an edge with `start`=1, capture the magnitude and sign:
    - SIGNED=1 and value[WIDTH-1]=1: magnitude = two's-complement negation, computed as an unsigned WIDTH-bit value, so 0x8000 gives 32768. `neg`_pending=1.
    - Otherwise magnitude = `value`, `neg`_pending=0.
  - Clear the BCD scratch and set count=0, then go to SHIFT.
  - `start`=0: stay in IDLE.
- SHIFT (busy=1):
  - Each edge, every scratch digit >= 5 gets +3.
  - Then shift {scratch, magnitude} left by one; the magnitude MSB enters scratch bit 0.
  - count increments each edge.
  - On the edge performing the WIDTH-th shift (count==WIDTH-1):
    - Load the `bcd` output register from the adjusted and shifted scratch.
    - Load `neg` from `neg`_pending.
    - Go to DONE.
- DONE (busy=0, done=1): lasts exactly one cycle, then returns to IDLE unconditionally.
- Handshake:
  - `start` is ignored in SHIFT and DONE; no queuing.
  - `value` is only sampled on the accepting edge, so later changes do not affect the conversion in flight.
- Latency:
  - If `start` is accepted at edge N, `busy` is high from after edge N until edge N+WIDTH.
  - `done` is high in the cycle between edges N+WIDTH and N+WIDTH+1.
  - The earliest next accept is at edge N+WIDTH+2 (start must be re-asserted or held).
  - For WIDTH=16: 16 cycles busy, 1 cycle done.
- Output stability: `bcd`/`neg` change only on the edge entering DONE, or on reset; they hold the last result otherwise.
- Zero: converts to `bcd`=0, `neg`=0. A negative zero cannot occur.
- Digit legality: every `bcd` nibble is 0-9 after any completed conversion.
- Held `start`: a continuously high `start` produces back-to-back conversions spaced WIDTH+2 edges apart.

Test Plan:
- Reset, then start with value=0x3039 (12345): `busy` high 16 cycles, then `done` one cycle with bcd=0x12345, neg=0.
- SIGNED=1:
  - value=0xFFFF gives neg=1, bcd=0x00001.
  - value=0x8000 gives neg=1, bcd=0x32768.
  - value=0x0000 gives neg=0, bcd=0x00000.
- SIGNED=0: value=0xFFFF gives neg=0, bcd=0x65535. Check every nibble is <=9 for a sweep of 1000 random values against a reference model.
- Start with value=0x0064 (100), then pulse start with value=0x0001 during SHIFT: the second start is ignored and the result is bcd=0x00100. A start held high gives a second `done` exactly 18 cycles after the first.
- Complete a conversion (bcd=0x00042), then start value=0x1234 and assert `reset` at SHIFT cycle 8. Next cycle: busy=0, done=0, bcd=0, neg=0, and no `done` pulse follows.
- `value` changes every cycle during SHIFT: the result equals the conversion of the value present on the accepting edge.
